// File: rtl/ocm_arbiter.sv
// ocm_arbiter
//   Responder side of the on-chip memory request/grant interface. Arbitrates
//   NUM_PORTS requesters round-robin and keeps the grant with the owner for as
//   long as it holds its request, so read-modify-write sequences issued by an
//   atomic unit are indivisible. Owns the word-addressed OCM array with
//   byte-enable writes and registered read data.
//
// Ports
//   clk         clock, all logic on posedge
//   rst         synchronous reset, active-high
//   i_request   per-port request, held for the whole transaction
//   i_addr      per-port word address, port p at [p*ADDR_BITS +: ADDR_BITS]
//   i_wdata     per-port write data, port p at [p*32 +: 32]
//   i_dm_write  per-port byte enables, port p at [p*4 +: 4]; 0 = read
//   o_grant     registered one-hot grant, all-zero when idle
//   o_rdata     registered read data, shared by all ports
//   o_busy      high while a port owns the memory
module ocm_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_BITS = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           i_request,
  input  logic [NUM_PORTS*ADDR_BITS-1:0] i_addr,
  input  logic [NUM_PORTS*32-1:0]        i_wdata,
  input  logic [NUM_PORTS*4-1:0]         i_dm_write,
  output logic [NUM_PORTS-1:0]           o_grant,
  output logic [31:0]                    o_rdata,
  output logic                           o_busy
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [31:0]            rdata_q;
  logic [IDX_W-1:0]       pick_idx;

  logic [31:0]            mem [0:DEPTH-1];

  logic [ADDR_BITS-1:0]   own_addr;
  logic [31:0]            own_wdata;
  logic [3:0]             own_be;

  assign own_addr  = i_addr[owner_q*ADDR_BITS +: ADDR_BITS];
  assign own_wdata = i_wdata[owner_q*32 +: 32];
  assign own_be    = i_dm_write[owner_q*4 +: 4];

  // Scan from the highest offset down so the requester closest to rr_ptr
  // (offset 0) is the last assignment and therefore wins.
  always_comb begin
    pick_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      int c;
      c = int'(rr_ptr_q) + k;
      if (c >= NUM_PORTS) c = c - NUM_PORTS;
      if (i_request[c]) pick_idx = IDX_W'(c);
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      S_IDLE: begin
        if (|i_request) begin
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          state_d           = S_BUSY;
        end
      end
      S_BUSY: begin
        // Release always returns to idle; a competing request is picked up
        // in the idle cycle, never handed over directly.
        if (!i_request[owner_q]) begin
          grant_d  = '0;
          rr_ptr_d = (owner_q == LAST_PORT) ? '0 : owner_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      if (state_q == S_BUSY) rdata_q <= mem[own_addr];
    end
  end

  // Array is never cleared; the reset edge only suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_BUSY) begin
      for (int b = 0; b < 4; b++) begin
        if (own_be[b]) mem[own_addr][8*b +: 8] <= own_wdata[8*b +: 8];
      end
    end
  end

  assign o_grant = grant_q;
  assign o_rdata = rdata_q;
  assign o_busy  = (state_q == S_BUSY);

endmodule

// File: tb/tb_ocm_arbiter.sv
module tb_ocm_arbiter;

  localparam int NP = 2;
  localparam int AB = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     i_request;
  logic [NP*AB-1:0]  i_addr;
  logic [NP*32-1:0]  i_wdata;
  logic [NP*4-1:0]   i_dm_write;
  logic [NP-1:0]     o_grant;
  logic [31:0]       o_rdata;
  logic              o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  ocm_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(AB)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_request  (i_request),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .i_dm_write (i_dm_write),
    .o_grant    (o_grant),
    .o_rdata    (o_rdata),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic req, input logic [AB-1:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    i_request[p]          = req;
    i_addr[p*AB +: AB]    = addr;
    i_wdata[p*32 +: 32]   = wdata;
    i_dm_write[p*4 +: 4]  = be;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    i_request  = '0;
    i_addr     = '0;
    i_wdata    = '0;
    i_dm_write = '0;
    do_reset();
    check("rst_grant", 32'(o_grant), 32'h0);
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_busy",  32'(o_busy), 32'h0);

    // 1: full-word write then read back on port 0
    drive(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    step();
    check("t1_grant", 32'(o_grant), 32'h1);
    check("t1_busy",  32'(o_busy), 32'h1);
    step();
    step();
    drive(0, 1'b1, 12'h010, 32'h0, 4'h0);
    step();
    check("t1_rdata", o_rdata, 32'hDEADBEEF);
    drive(0, 1'b0, 12'h010, 32'h0, 4'h0);
    step();
    check("t1_rel_grant", 32'(o_grant), 32'h0);
    check("t1_rel_busy",  32'(o_busy), 32'h0);

    // 2: byte enables (rr_ptr now 1; a lone request still wins)
    drive(0, 1'b1, 12'h020, 32'h11223344, 4'hF);
    step();
    check("t2_grant", 32'(o_grant), 32'h1);
    step();
    drive(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'b0101);
    step();
    check("t2_rbw", o_rdata, 32'h11223344);
    drive(0, 1'b1, 12'h020, 32'h0, 4'h0);
    step();
    check("t2_be", o_rdata, 32'h11BB33DD);
    drive(0, 1'b0, 12'h020, 32'h0, 4'h0);
    step();

    // 5: read-before-write on port 1
    drive(1, 1'b1, 12'h040, 32'h3, 4'hF);
    step();
    check("t5_grant", 32'(o_grant), 32'h2);
    step();
    drive(1, 1'b1, 12'h040, 32'h7, 4'hF);
    step();
    check("t5_old", o_rdata, 32'h3);
    drive(1, 1'b1, 12'h040, 32'h0, 4'h0);
    step();
    check("t5_new", o_rdata, 32'h7);
    drive(1, 1'b0, 12'h040, 32'h0, 4'h0);
    step();

    // 3: simultaneous requests after reset, round-robin order
    do_reset();
    drive(0, 1'b1, 12'h010, 32'h0, 4'h0);
    drive(1, 1'b1, 12'h020, 32'h0, 4'h0);
    step();
    check("t3_first", 32'(o_grant), 32'h1);
    step();
    drive(0, 1'b0, 12'h010, 32'h0, 4'h0);
    step();
    check("t3_idle_gap", 32'(o_grant), 32'h0);
    check("t3_idle_busy", 32'(o_busy), 32'h0);
    step();
    check("t3_second", 32'(o_grant), 32'h2);
    step();
    check("t3_p1_rdata", o_rdata, 32'h11BB33DD);
    drive(1, 1'b0, 12'h020, 32'h0, 4'h0);
    step();
    check("t3_rel1", 32'(o_grant), 32'h0);
    drive(0, 1'b1, 12'h010, 32'h0, 4'h0);
    drive(1, 1'b1, 12'h020, 32'h0, 4'h0);
    step();
    check("t3_again_p0", 32'(o_grant), 32'h1);
    drive(0, 1'b0, 12'h010, 32'h0, 4'h0);
    drive(1, 1'b0, 12'h020, 32'h0, 4'h0);
    step();
    check("t3_rel_all", 32'(o_grant), 32'h0);
    step();

    // Preload 0x030 = 5 via port 1 (rr_ptr is 1 here)
    drive(1, 1'b1, 12'h030, 32'h5, 4'hF);
    step();
    check("t4_pre_grant", 32'(o_grant), 32'h2);
    step();
    drive(1, 1'b0, 12'h030, 32'h0, 4'h0);
    step();
    // rr_ptr is 0 now; port 1 raises alone, port 0 joins after it owns
    drive(1, 1'b1, 12'h030, 32'h0, 4'h0);
    step();
    check("t4_p1_grant", 32'(o_grant), 32'h2);
    drive(0, 1'b1, 12'h050, 32'h0, 4'h0);
    step();
    check("t4_read5", o_rdata, 32'h5);
    drive(1, 1'b1, 12'h030, 32'h6, 4'hF);
    step();
    check("t4_hold_a", 32'(o_grant), 32'h2);
    drive(1, 1'b1, 12'h030, 32'h0, 4'h0);
    step();
    check("t4_read6", o_rdata, 32'h6);
    check("t4_hold_b", 32'(o_grant), 32'h2);
    step();
    check("t4_hold_c", 32'(o_grant), 32'h2);
    drive(1, 1'b0, 12'h030, 32'h0, 4'h0);
    step();
    check("t4_release_wins", 32'(o_grant), 32'h0);
    drive(0, 1'b1, 12'h030, 32'h0, 4'h0);
    step();
    check("t4_p0_grant", 32'(o_grant), 32'h1);
    step();
    check("t4_p0_sees6", o_rdata, 32'h6);

    // 6: reset during port 0 write burst
    drive(0, 1'b1, 12'h060, 32'hA5A5A5A5, 4'hF);
    step();
    drive(0, 1'b1, 12'h060, 32'hFFFFFFFF, 4'hF);
    rst = 1'b1;
    step();
    check("t6_rst_grant", 32'(o_grant), 32'h0);
    check("t6_rst_rdata", o_rdata, 32'h0);
    check("t6_rst_busy",  32'(o_busy), 32'h0);
    rst = 1'b0;
    drive(0, 1'b1, 12'h060, 32'h0, 4'h0);
    step();
    check("t6_regrant", 32'(o_grant), 32'h1);
    step();
    check("t6_no_rst_write", o_rdata, 32'hA5A5A5A5);
    drive(0, 1'b1, 12'h010, 32'h0, 4'h0);
    step();
    check("t6_persist", o_rdata, 32'hDEADBEEF);
    drive(0, 1'b0, 12'h010, 32'h0, 4'h0);
    step();
    check("t6_final_grant", 32'(o_grant), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
